// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {co, s} = a - b - c, one-cycle latency.
// Optional sticky borrow flag enabled by defining FULL_SUBTRACTOR_STICKY_BORROW_EN.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
    input  logic             borrow_clr,
    output logic             borrow_sticky,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0]   bin;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] s_q,  s_d;
    logic             co_q, co_d;
    logic             vld_q;

    // Chain of 1-bit full-subtractor cells, borrow rippling from LSB.
    always_comb begin
        bin[0] = c;
        diff   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]  = a[i] ^ b[i] ^ bin[i];
            bin[i+1] = (~a[i] & b[i]) | (~a[i] & bin[i]) | (b[i] & bin[i]);
        end
    end

    // Capture a new result only when operands are valid; otherwise hold.
    always_comb begin
        s_d  = s_q;
        co_d = co_q;
        if (in_valid) begin
            s_d  = diff;
            co_d = bin[WIDTH];
        end
    end

    // Result and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            co_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            co_q  <= co_d;
            vld_q <= in_valid;
        end
    end

    assign s         = s_q;
    assign co        = co_q;
    assign out_valid = vld_q;

`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
    logic sticky_q, sticky_d;

    // A fresh borrow sets the flag; set has priority over clear.
    always_comb begin
        sticky_d = (in_valid & bin[WIDTH]) | (sticky_q & ~borrow_clr);
    end

    // Sticky flag register, updated alongside co.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign borrow_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: WIDTH=1 and WIDTH=8 instances against an
// arithmetic reference model, directed boundaries plus random streams.
module tb_full_subtractor;

    logic       clk;
    logic       rst_n;
    logic       iv;
    logic       clr;
    logic       a1, b1, c1;
    logic [7:0] a8, b8;
    logic       c8;
    logic       ov1, s1, co1;
    logic       ov8, co8;
    logic [7:0] s8;
    logic       st1, st8;

    int checks = 0;
    int fails  = 0;

    logic       e_s1, e_co1, e_st1, e_st8;
    logic [7:0] e_s8;
    logic       e_co8;

    logic [7:0] ts;
    logic [7:0] tco;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv),
        .a(a1), .b(b1), .c(c1),
`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
        .borrow_clr(clr), .borrow_sticky(st1),
`endif
        .out_valid(ov1), .s(s1), .co(co1)
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv),
        .a(a8), .b(b8), .c(c8),
`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
        .borrow_clr(clr), .borrow_sticky(st8),
`endif
        .out_valid(ov8), .s(s8), .co(co8)
    );

`ifndef FULL_SUBTRACTOR_STICKY_BORROW_EN
    assign st1 = 1'b0;
    assign st8 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed arithmetic, borrow is the sign of a-b-c.
    function automatic logic [8:0] ref_sub(input int w, input int xa,
                                           input int xb, input int xc);
        int d;
        d = xa - xb - xc;
        ref_sub[7:0] = 8'(d & ((1 << w) - 1));
        ref_sub[8]   = (d < 0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] xa8,
                         input logic [7:0] xb8, input logic xc8,
                         input logic xa1, input logic xb1, input logic xc1);
        logic [8:0] r;
        iv = v;
        a8 = xa8; b8 = xb8; c8 = xc8;
        a1 = xa1; b1 = xb1; c1 = xc1;
        if (v) begin
            r = ref_sub(8, int'(xa8), int'(xb8), int'(xc8));
            e_s8 = r[7:0]; e_co8 = r[8];
            r = ref_sub(1, int'(xa1), int'(xb1), int'(xc1));
            e_s1 = r[0]; e_co1 = r[8];
        end
        e_st8 = (v && e_co8) ? 1'b1 : (clr ? 1'b0 : e_st8);
        e_st1 = (v && e_co1) ? 1'b1 : (clr ? 1'b0 : e_st1);
        @(posedge clk);
        #1;
        chk("ov8", {7'd0, ov8}, {7'd0, v});
        chk("s8", s8, e_s8);
        chk("co8", {7'd0, co8}, {7'd0, e_co8});
        chk("ov1", {7'd0, ov1}, {7'd0, v});
        chk("s1", {7'd0, s1}, {7'd0, e_s1});
        chk("co1", {7'd0, co1}, {7'd0, e_co1});
`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
        chk("st8", {7'd0, st8}, {7'd0, e_st8});
        chk("st1", {7'd0, st1}, {7'd0, e_st1});
`endif
        @(negedge clk);
    endtask

    function automatic logic [7:0] r8();
        return 8'($urandom_range(255));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(1));
    endfunction

    initial begin
        rst_n = 1'b0;
        iv = 1'b0; clr = 1'b0;
        a1 = 0; b1 = 0; c1 = 0;
        a8 = 0; b8 = 0; c8 = 0;
        e_s1 = 0; e_co1 = 0; e_s8 = 0; e_co8 = 0;
        e_st1 = 0; e_st8 = 0;
        ts  = 8'b1001_0110;
        tco = 8'b1000_1110;

        #2;
        chk("rst_s8", s8, 8'h00);
        chk("rst_co8", {7'd0, co8}, 8'h00);
        chk("rst_ov8", {7'd0, ov8}, 8'h00);
        chk("rst_s1", {7'd0, s1}, 8'h00);
        chk("rst_ov1", {7'd0, ov1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // WIDTH=1 exhaustive truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            cycle(1, r8(), r8(), r1(), abc[2], abc[1], abc[0]);
            chk("tt_s", {7'd0, s1}, {7'd0, ts[v]});
            chk("tt_co", {7'd0, co1}, {7'd0, tco[v]});
        end

        // WIDTH=8 directed and boundary vectors
        cycle(1, 8'h10, 8'h01, 1, r1(), r1(), r1());
        chk("d1_s", s8, 8'h0E);
        chk("d1_co", {7'd0, co8}, 8'h00);
        cycle(1, 8'h00, 8'h00, 1, r1(), r1(), r1());
        chk("d2_s", s8, 8'hFF);
        chk("d2_co", {7'd0, co8}, 8'h01);
        cycle(1, 8'h7F, 8'h80, 0, r1(), r1(), r1());
        chk("d3_s", s8, 8'hFF);
        chk("d3_co", {7'd0, co8}, 8'h01);
        cycle(1, 8'hFF, 8'hFF, 1, 1, 1, 1);
        chk("b_ones_s", s8, 8'hFF);
        chk("b_ones_co", {7'd0, co8}, 8'h01);
        cycle(1, 8'hA5, 8'hA5, 0, 1, 1, 0);
        chk("b_eq_s", s8, 8'h00);
        chk("b_eq_co", {7'd0, co8}, 8'h00);

        // Hold: one valid op then idle cycles with junk operands
        cycle(1, 8'h3C, 8'h5A, 1, 1, 0, 1);
        cycle(0, r8(), r8(), r1(), r1(), r1(), r1());
        cycle(0, r8(), r8(), r1(), r1(), r1(), r1());
        cycle(0, 8'hxx, 8'hxx, 1'bx, 1'bx, 1'bx, 1'bx);

        // Throughput: back-to-back random vectors
        for (int i = 0; i < 16; i++) begin
            cycle(1, r8(), r8(), r1(), r1(), r1(), r1());
        end

        // Asynchronous reset mid-cycle with s1=1/co1=1 in flight
        cycle(1, 8'hFF, 8'h01, 0, 0, 0, 1);
        chk("pre_rst_s1", {7'd0, s1}, 8'h01);
        chk("pre_rst_co1", {7'd0, co1}, 8'h01);
        iv = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s1", {7'd0, s1}, 8'h00);
        chk("arst_co1", {7'd0, co1}, 8'h00);
        chk("arst_ov1", {7'd0, ov1}, 8'h00);
        chk("arst_s8", s8, 8'h00);
        chk("arst_ov8", {7'd0, ov8}, 8'h00);
        e_s1 = 0; e_co1 = 0; e_s8 = 0; e_co8 = 0;
        e_st1 = 0; e_st8 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        iv = 1'b0;
        cycle(0, r8(), r8(), r1(), r1(), r1(), r1());

`ifdef FULL_SUBTRACTOR_STICKY_BORROW_EN
        cycle(1, 8'h00, 8'h01, 0, 0, 1, 0);
        cycle(1, 8'h05, 8'h01, 0, 1, 0, 0);
        cycle(1, 8'h09, 8'h02, 0, 1, 1, 0);
        chk("st_hold", {7'd0, st8}, 8'h01);
        clr = 1'b1;
        cycle(0, r8(), r8(), r1(), r1(), r1(), r1());
        chk("st_clr", {7'd0, st8}, 8'h00);
        cycle(1, 8'h00, 8'h01, 0, 0, 1, 0);
        chk("st_setwins", {7'd0, st8}, 8'h01);
        clr = 1'b0;
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
